// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encoding and sizing for the HI/LO mul/div sequencer
package muldiv_pkg;

   localparam int MD_WIDTH   = 32;
   localparam int ITER_CNT_W = $clog2(MD_WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// rtl/muldiv_iter_dp.sv - iterative shift-add / restoring-divide datapath with sign fix-up (FAST_MUL_EN adds a combinational product)
module muldiv_iter_dp
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o
`ifdef FAST_MUL_EN
   ,
   output logic [WIDTH-1:0] fast_hi_o,
   output logic [WIDTH-1:0] fast_lo_o
`endif
);

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic               is_div_q, neg_lo_q, neg_hi_q, div0_q;

   logic               signed_op, is_div, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     add_sum, rem_sh, trial;
   logic [2*WIDTH-1:0] prod_fix;

   assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign a_neg     = signed_op & a_i[WIDTH-1];
   assign b_neg     = signed_op & b_i[WIDTH-1];
   assign a_mag     = cond_neg(a_i, a_neg);
   assign b_mag     = cond_neg(b_i, b_neg);

   // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
   assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
   assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
   assign trial   = rem_sh - {1'b0, opnd_q};

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      end else if (step_i) begin
         if (!is_div_q)
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
         else if (trial[WIDTH])
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
         else
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (load_i) begin
            opnd_q   <= is_div ? b_mag : a_mag;
            is_div_q <= is_div;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
            div0_q   <= is_div && (b_i == '0);
         end
      end
   end

   assign prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      if (is_div_q) begin
         // The restoring loop already leaves |dividend| as remainder on /0; only the quotient is forced.
         res_lo_o = div0_q ? '1 : cond_neg(acc_q[WIDTH-1:0], neg_lo_q);
         res_hi_o = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
      end else begin
         res_lo_o = prod_fix[WIDTH-1:0];
         res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_mag, fast_prod;
   assign fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
   assign fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
   assign fast_hi_o = fast_prod[2*WIDTH-1:WIDTH];
   assign fast_lo_o = fast_prod[WIDTH-1:0];
`endif

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO owner: handshake, cancel, iteration FSM (FAST_MUL_EN selects single-cycle multiply)
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e                  state_q, state_d;
   logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
   logic                    load, step;
   logic [WIDTH-1:0]        res_hi, res_lo;
`ifdef FAST_MUL_EN
   logic [WIDTH-1:0]        fast_hi, fast_lo;
`endif

   muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .resetn   (resetn),
      .load_i   (load),
      .step_i   (step),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .res_hi_o (res_hi),
      .res_lo_o (res_lo)
`ifdef FAST_MUL_EN
      ,
      .fast_hi_o(fast_hi),
      .fast_lo_o(fast_lo)
`endif
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_i && !cancel_i) begin
               case (op_i)
                  OP_MTHI: hi_d = a_i;
                  OP_MTLO: lo_d = a_i;
                  OP_MULT, OP_MULTU: begin
`ifdef FAST_MUL_EN
                     hi_d    = fast_hi;
                     lo_d    = fast_lo;
                     state_d = ST_DONE;
`else
                     load    = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_CALC;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     load    = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_CALC;
                  end
                  default: ;
               endcase
            end
         end
         ST_CALC: begin
            if (cancel_i) begin
               state_d = ST_IDLE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == ITER_CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            // Commit happens here so DONE already presents the new HI/LO.
            if (cancel_i) begin
               state_d = ST_IDLE;
            end else begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = (state_q != ST_IDLE);
   assign done_o  = (state_q == ST_DONE);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers of the CPU datapath. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation at a time over a req/ready handshake and runs an iterative shift-add or restoring-divide loop. It signals done to stall/unstall the pipeline and supports cancel on exception flush. It sits beside the single-cycle ALU in the execute stage.

Parameters:
WIDTH, 32, operand width; iteration count = WIDTH; only 32 is required to be verified.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_i  in  1  operation request, sampled when ready_o=1
op_i  in  3  operation code (see package)
a_i  in  WIDTH  rs operand / dividend / MT data
b_i  in  WIDTH  rt operand / divisor
cancel_i  in  1  flush; abort in-flight operation
ready_o  out  1  idle, can accept
busy_o  out  1  multi-cycle op in flight
done_o  out  1  one-cycle pulse, HI/LO just updated
hi_o  out  WIDTH  architectural HI
lo_o  out  WIDTH  architectural LO

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi_o=lo_o=0, done_o=0, busy_o=0, ready_o=1, counter=0.
- States: IDLE, CALC, FIX, DONE. ready_o = (state==IDLE); busy_o = (state!=IDLE).
- Accept = req_i & ready_o & ~cancel_i in cycle 0.
- MTHI/MTLO: hi_o or lo_o written at the end of cycle 0; stay IDLE; no done_o.
- Undefined opcodes (6, 7): accepted and ignored.
- MULT/MULTU/DIV/DIVU: latch operands; signed ops take magnitudes and record the result signs. IDLE->CALC.
  - CALC: one iteration per cycle for exactly WIDTH cycles (cycles 1..32).
  - FIX (cycle 33): sign correction. Signed MULT negates the 64-bit product if the signs differ. DIV: quotient negative iff the signs differ; remainder takes the sign of the dividend.
  - DONE (cycle 34): hi_o/lo_o are already holding the new result; done_o=1 for exactly this cycle; then IDLE (ready_o=1 in cycle 35).
- Results: MULT{U}: {hi,lo} = 64-bit product. DIV{U}: lo = quotient, hi = remainder.
- Divide by zero (b=0, signed or unsigned): lo=32'hFFFF_FFFF, hi=a_i. Same latency as a normal divide.
- 0x8000_0000 / 0xFFFF_FFFF (signed): lo=0x8000_0000, hi=0. No trap.
- hi_o/lo_o hold their old values throughout CALC/FIX.
- cancel_i:
  - In IDLE, cancel wins over req_i; the request is dropped.
  - In CALC or FIX, return to IDLE next edge with no HI/LO write and no done_o.
  - In DONE, ignored; the result is already committed.
- A req_i while busy is not accepted; the requester holds it.
- Asynchronous reset mid-operation: immediate return to reset values.

Optional Feature:
FAST_MUL_EN
- Defined: MULT/MULTU use a combinational 32x32 multiply and go IDLE->DONE directly. done_o is in cycle 1 and HI/LO are written at the end of cycle 0. DIV paths are unchanged.
- Undefined: all multiplies take the 34-cycle iterative path.
- Cancel semantics are unchanged. In fast mode the multiply commits at accept, so cancel does not apply to it.

Decomposition:
- Package muldiv_pkg holds:
  - op codes: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5;
  - state encoding;
  - ITER_CNT_W=$clog2(WIDTH)+1.
- Sub-module muldiv_iter_dp holds the iteration datapath: the 64-bit partial product/remainder shifter, the add/subtract-compare step, and the magnitude/negate helpers.
- hilo_muldiv_ctrl keeps the FSM, counter, handshake and HI/LO registers.

Test Plan:
- MULTU a=0xFFFF_FFFF b=2 -> hi=0x1, lo=0xFFFF_FFFE; done_o only in cycle 34 (cycle 1 with FAST_MUL_EN); ready_o low cycles 1-34.
- MULT a=0xFFFF_FFFD(-3) b=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1; MULT 0x8000_0000 x 0x8000_0000 -> hi=0x4000_0000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU a=7 b=2 -> lo=3, hi=1; DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU a=5 b=0 -> lo=0xFFFF_FFFF, hi=5, done_o at cycle 34; DIV a=-5 b=0 -> lo=0xFFFF_FFFF, hi=0xFFFF_FFFB.
- MTHI 0x1234 then DIV with cancel_i at cycle 10 -> no done_o, hi=0x1234 and lo unchanged, ready_o=1 in cycle 11; next MTLO 0xAB accepted, lo=0xAB.
- MTHI req while busy -> not accepted, hi unchanged until retried in IDLE; resetn pulse at cycle 20 of DIVU -> hi=lo=0, ready_o=1 immediately, no done_o.
